stage_memory: RTL



---
 rtl/stage_memory.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/stage_memory.sv
// -----------------------------------------------------------------------------
// stage_memory
//
// MEM stage of a five-stage MIPS pipeline. It takes the EX/MEM latch contents,
// performs byte, half-word and word loads and stores on an internal synchronous
// data memory, and registers the MEM/WB latch that feeds write-back.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rst                 synchronous reset, active-low
//   is_enable           pipeline advance from the debug unit (0 = hold, no write)
//   i_ALU_res           byte address for loads/stores, pass-through otherwise
//   i_rt_reg            store data
//   i_pc_to_reg         link value for jal/jalr
//   i_addr_reg_dst      destination register
//   is_RegWrite, is_MemtoReg, is_MemWrite, is_MemRead, is_link, is_stop_pipe
//                       EX/MEM control
//   is_load_store_type  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU,
//                       any other code is treated as a word access
//   i_debug_addr        debug word address
//   o_read_data         sign/zero-extended load result
//   o_ALU_res, o_pc_to_reg, o_addr_reg_dst   registered pass-through
//   os_RegWrite, os_MemtoReg, os_link, os_stop_pipe   registered control
//   os_misaligned       sticky misaligned-access flag, cleared only by reset
//   o_debug_data        memory word at i_debug_addr, one cycle later
// -----------------------------------------------------------------------------
module stage_memory #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_enable,
    input  logic [31:0]       i_ALU_res,
    input  logic [31:0]       i_rt_reg,
    input  logic [31:0]       i_pc_to_reg,
    input  logic [4:0]        i_addr_reg_dst,
    input  logic              is_RegWrite,
    input  logic              is_MemtoReg,
    input  logic              is_MemWrite,
    input  logic              is_MemRead,
    input  logic              is_link,
    input  logic              is_stop_pipe,
    input  logic [2:0]        is_load_store_type,
    input  logic [ADDR_W-1:0] i_debug_addr,
    output logic [31:0]       o_read_data,
    output logic [31:0]       o_ALU_res,
    output logic [31:0]       o_pc_to_reg,
    output logic [4:0]        o_addr_reg_dst,
    output logic              os_RegWrite,
    output logic              os_MemtoReg,
    output logic              os_link,
    output logic              os_stop_pipe,
    output logic              os_misaligned,
    output logic [31:0]       o_debug_data
);

    localparam int DEPTH = 1 << ADDR_W;

    // Access size, kept in the MEM/WB latch so the load extension lines up
    // with the word read out of the memory.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [31:0] mem_q [DEPTH];

    // ---------------------------------------------------------------- decode
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [1:0]        size;
    logic              misaligned_now;
    logic              store_en;
    logic [3:0]        byte_en;
    logic [31:0]       wdata;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        word_idx = i_ALU_res[ADDR_W+1:2];   // upper address bits wrap
        lane     = i_ALU_res[1:0];
        size     = SZ_WORD;
        byte_en  = 4'b1111;
        wdata    = i_rt_reg;

        case (is_load_store_type)
            3'b000, 3'b100: size = SZ_BYTE;
            3'b001, 3'b101: size = SZ_HALF;
            default:        size = SZ_WORD;
        endcase

        misaligned_now = (is_MemRead || is_MemWrite) &&
                         (((size == SZ_HALF) && lane[0]) ||
                          ((size == SZ_WORD) && (lane != 2'b00)));

        // Store data is replicated across lanes; byte_en picks the lanes.
        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << lane;
                wdata   = {4{i_rt_reg[7:0]}};
            end
            SZ_HALF: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{i_rt_reg[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wdata   = i_rt_reg;
            end
        endcase

        store_en = rst && is_enable && is_MemWrite && !misaligned_now;
    end

    // ---------------------------------------------------------------- memory
    // NOTE: the array has no reset; contents come from device configuration
    // and survive rst, which also lets it map onto block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (store_en && byte_en[b]) begin
                mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------- MEM/WB latch
    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  dst_q, dst_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic        link_q, link_d;
    logic        stop_q, stop_d;
    logic        misaligned_q, misaligned_d;
    logic        load_ok_q, load_ok_d;     // aligned read-only access
    logic        unsigned_q, unsigned_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q;
    logic [31:0] debug_q;

    always_comb begin
        alu_res_d    = alu_res_q;
        pc_d         = pc_q;
        dst_d        = dst_q;
        regwrite_d   = regwrite_q;
        memtoreg_d   = memtoreg_q;
        link_d       = link_q;
        stop_d       = stop_q;
        misaligned_d = misaligned_q;
        load_ok_d    = load_ok_q;
        unsigned_d   = unsigned_q;
        size_d       = size_q;
        lane_d       = lane_q;
        if (is_enable) begin
            alu_res_d    = i_ALU_res;
            pc_d         = i_pc_to_reg;
            dst_d        = i_addr_reg_dst;
            regwrite_d   = is_RegWrite;
            memtoreg_d   = is_MemtoReg;
            link_d       = is_link;
            stop_d       = is_stop_pipe;
            misaligned_d = misaligned_q || misaligned_now;
            // A simultaneous read+write returns zero, as does a misaligned load.
            load_ok_d    = is_MemRead && !is_MemWrite && !misaligned_now;
            unsigned_d   = is_load_store_type[2];
            size_d       = size;
            lane_d       = lane;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_res_q    <= '0;
            pc_q         <= '0;
            dst_q        <= '0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            link_q       <= 1'b0;
            stop_q       <= 1'b0;
            misaligned_q <= 1'b0;
            load_ok_q    <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= SZ_WORD;
            lane_q       <= 2'b00;
            word_q       <= '0;
            debug_q      <= '0;
        end else begin
            alu_res_q    <= alu_res_d;
            pc_q         <= pc_d;
            dst_q        <= dst_d;
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            link_q       <= link_d;
            stop_q       <= stop_d;
            misaligned_q <= misaligned_d;
            load_ok_q    <= load_ok_d;
            unsigned_q   <= unsigned_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            if (is_enable) begin
                word_q <= mem_q[word_idx];
            end
            // Read-before-write: a same-cycle store is not yet visible here.
            debug_q <= mem_q[i_debug_addr];
        end
    end

    // ------------------------------------------------------- load extension
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte    = word_q[{lane_q, 3'b000} +: 8];
        sel_half    = word_q[{lane_q[1], 4'b0000} +: 16];
        o_read_data = '0;
        if (load_ok_q) begin
            case (size_q)
                SZ_BYTE: o_read_data = unsigned_q ? {24'd0, sel_byte}
                                                  : {{24{sel_byte[7]}}, sel_byte};
                SZ_HALF: o_read_data = unsigned_q ? {16'd0, sel_half}
                                                  : {{16{sel_half[15]}}, sel_half};
                default: o_read_data = word_q;
            endcase
        end
    end

    assign o_ALU_res      = alu_res_q;
    assign o_pc_to_reg    = pc_q;
    assign o_addr_reg_dst = dst_q;
    assign os_RegWrite    = regwrite_q;
    assign os_MemtoReg    = memtoreg_q;
    assign os_link        = link_q;
    assign os_stop_pipe   = stop_q;
    assign os_misaligned  = misaligned_q;
    assign o_debug_data   = debug_q;

endmodule
